reservation_station: RTL

//  Out-of-order holding buffer for ALU-class instructions, between decoder/dispatch and the combinational ALU.

---
 rtl/reservation_station.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/reservation_station.sv
// Reservation station for ALU-class ops: holds dispatched instructions, snoops the
// ALU and LSB result buses for missing operands, and issues one ready op per cycle.
module reservation_station #(
    parameter int RS_SIZE = 16,
    parameter int TAG_W   = 6
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear_in,

    input  logic             dsp_valid,
    input  logic [5:0]       dsp_opcode,
    input  logic [31:0]      dsp_val1,
    input  logic [31:0]      dsp_val2,
    input  logic [TAG_W-1:0] dsp_q1,
    input  logic [TAG_W-1:0] dsp_q2,
    input  logic             dsp_q1_rdy,
    input  logic             dsp_q2_rdy,
    input  logic [31:0]      dsp_imm,
    input  logic [31:0]      dsp_pc,
    input  logic [TAG_W-1:0] dsp_rob_index,
    output logic             rs_full,

    input  logic             alu_cdb_valid,
    input  logic [TAG_W-1:0] alu_cdb_rob,
    input  logic [31:0]      alu_cdb_res,
    input  logic             lsb_cdb_valid,
    input  logic [TAG_W-1:0] lsb_cdb_rob,
    input  logic [31:0]      lsb_cdb_res,

    output logic [5:0]       ex_opcode,
    output logic [31:0]      ex_val1,
    output logic [31:0]      ex_val2,
    output logic [31:0]      ex_imm,
    output logic [31:0]      ex_pc,
    output logic [TAG_W-1:0] ex_rob_index
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] r_busy;
    logic [RS_SIZE-1:0] r_rdy1;
    logic [RS_SIZE-1:0] r_rdy2;
    logic [5:0]         r_op   [RS_SIZE];
    logic [31:0]        r_val1 [RS_SIZE];
    logic [31:0]        r_val2 [RS_SIZE];
    logic [31:0]        r_imm  [RS_SIZE];
    logic [31:0]        r_pc   [RS_SIZE];
    logic [TAG_W-1:0]   r_q1   [RS_SIZE];
    logic [TAG_W-1:0]   r_q2   [RS_SIZE];
    logic [TAG_W-1:0]   r_rob  [RS_SIZE];

    logic [RS_SIZE-1:0] w_ready;
    logic               w_sel_found;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_free_found;
    logic [IDX_W-1:0]   w_free_idx;
    logic               w_dsp_go;
    logic               w_d1_rdy;
    logic               w_d2_rdy;
    logic [31:0]        w_d1_val;
    logic [31:0]        w_d2_val;

    assign w_ready  = r_busy & r_rdy1 & r_rdy2;
    // The entry issuing this cycle is still busy here, so it never counts as free.
    assign rs_full  = &r_busy;
    assign w_dsp_go = dsp_valid & w_free_found;

    // Descending scan: the last hit written is the lowest index.
    always_comb begin
        w_sel_found  = 1'b0;
        w_sel_idx    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    // Dispatch bypass: a missing operand produced on a result bus this cycle is stored ready.
    always_comb begin
        w_d1_rdy = dsp_q1_rdy;
        w_d1_val = dsp_val1;
        if (!dsp_q1_rdy) begin
            if (alu_cdb_valid && alu_cdb_rob == dsp_q1) begin
                w_d1_rdy = 1'b1;
                w_d1_val = alu_cdb_res;
            end else if (lsb_cdb_valid && lsb_cdb_rob == dsp_q1) begin
                w_d1_rdy = 1'b1;
                w_d1_val = lsb_cdb_res;
            end
        end
    end

    always_comb begin
        w_d2_rdy = dsp_q2_rdy;
        w_d2_val = dsp_val2;
        if (!dsp_q2_rdy) begin
            if (alu_cdb_valid && alu_cdb_rob == dsp_q2) begin
                w_d2_rdy = 1'b1;
                w_d2_val = alu_cdb_res;
            end else if (lsb_cdb_valid && lsb_cdb_rob == dsp_q2) begin
                w_d2_rdy = 1'b1;
                w_d2_val = lsb_cdb_res;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy       <= '0;
            r_rdy1       <= '0;
            r_rdy2       <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_op[i]   <= '0;
                r_val1[i] <= '0;
                r_val2[i] <= '0;
                r_imm[i]  <= '0;
                r_pc[i]   <= '0;
                r_q1[i]   <= '0;
                r_q2[i]   <= '0;
                r_rob[i]  <= '0;
            end
            ex_opcode    <= '0;
            ex_val1      <= '0;
            ex_val2      <= '0;
            ex_imm       <= '0;
            ex_pc        <= '0;
            ex_rob_index <= '0;
        end else if (!rdy_in) begin
            // Frozen: entries hold, but the ALU must not see the last op twice.
            ex_opcode <= '0;
        end else if (clear_in) begin
            r_busy    <= '0;
            ex_opcode <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && !r_rdy1[i]) begin
                    if (alu_cdb_valid && alu_cdb_rob == r_q1[i]) begin
                        r_val1[i] <= alu_cdb_res;
                        r_rdy1[i] <= 1'b1;
                    end else if (lsb_cdb_valid && lsb_cdb_rob == r_q1[i]) begin
                        r_val1[i] <= lsb_cdb_res;
                        r_rdy1[i] <= 1'b1;
                    end
                end
                if (r_busy[i] && !r_rdy2[i]) begin
                    if (alu_cdb_valid && alu_cdb_rob == r_q2[i]) begin
                        r_val2[i] <= alu_cdb_res;
                        r_rdy2[i] <= 1'b1;
                    end else if (lsb_cdb_valid && lsb_cdb_rob == r_q2[i]) begin
                        r_val2[i] <= lsb_cdb_res;
                        r_rdy2[i] <= 1'b1;
                    end
                end
            end

            if (w_sel_found) begin
                ex_opcode         <= r_op[w_sel_idx];
                ex_val1           <= r_val1[w_sel_idx];
                ex_val2           <= r_val2[w_sel_idx];
                ex_imm            <= r_imm[w_sel_idx];
                ex_pc             <= r_pc[w_sel_idx];
                ex_rob_index      <= r_rob[w_sel_idx];
                r_busy[w_sel_idx] <= 1'b0;
            end else begin
                ex_opcode <= '0;
            end

            // The free entry is never the issuing one, so these writes do not collide.
            if (w_dsp_go) begin
                r_busy[w_free_idx] <= 1'b1;
                r_op[w_free_idx]   <= dsp_opcode;
                r_val1[w_free_idx] <= w_d1_val;
                r_val2[w_free_idx] <= w_d2_val;
                r_rdy1[w_free_idx] <= w_d1_rdy;
                r_rdy2[w_free_idx] <= w_d2_rdy;
                r_q1[w_free_idx]   <= dsp_q1;
                r_q2[w_free_idx]   <= dsp_q2;
                r_imm[w_free_idx]  <= dsp_imm;
                r_pc[w_free_idx]   <= dsp_pc;
                r_rob[w_free_idx]  <= dsp_rob_index;
            end
        end
    end

endmodule
